nios2_cpu_mult_pipe: RTL and testbench

NIOS2_CPU_MULT_PIPE -- requirements
Module: nios2_cpu_mult_pipe

---
 rtl/nios2_cpu_mult_pkg.sv | 17 +
 rtl/nios2_cpu_mult_pp.sv | 20 ++
 rtl/nios2_cpu_mult_pipe.sv | 130 +++++++++++++
 tb/tb_nios2_cpu_mult_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nios2_cpu_mult_pkg.sv
// Shared definitions for the pipelined integer multiplier.
//   mode_e      : operation select (MUL low word, MULX* high words)
//   PP_W        : width of one partial-product operand slice
//   PIPE_STAGES : number of register stages between accept and result
package nios2_cpu_mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } mode_e;

  localparam int PP_W        = 16;
  localparam int PIPE_STAGES = 2;

endpackage

// File: rtl/nios2_cpu_mult_pp.sv
// One registered 16x16 unsigned partial product.
//   clk : clock
//   en  : hold enable (register loads only when high)
//   a,b : PP_W-bit unsigned operand slices
//   p   : registered 2*PP_W-bit product
module nios2_cpu_mult_pp
  import nios2_cpu_mult_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [PP_W-1:0]   a,
  input  logic [PP_W-1:0]   b,
  output logic [2*PP_W-1:0] p
);

  always_ff @(posedge clk) begin
    if (en) p <= a * b;
  end

endmodule

// File: rtl/nios2_cpu_mult_pipe.sv
// Two-stage pipelined multiplier with valid/ready handshake and tag sideband.
//   S1: 16x16 partial products (+ signed correction term and mode)
//   S2: summed product, selected word -> out_result / out_tag
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in_mode/in_src1/
//   in_src2/in_tag (request), out_valid/out_ready/out_result/out_tag (result).
// Config macro NIOS2_CPU_MULT_HIGH_EN: when defined, all four modes are built.
//   When undefined, only partial products that reach the low word exist,
//   in_mode is ignored and out_result is always the low product word.
// DATA_W must be a multiple of 16 in 16..64.
module nios2_cpu_mult_pipe
  import nios2_cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NS = DATA_W / PP_W;   // operand slices
  localparam int PW = 2 * DATA_W;      // full product width

  logic                   stall, en, accept;
  logic [PIPE_STAGES:1]   vld_pipe;
  logic [2*PP_W-1:0]      pp [NS*NS];
  logic [TAG_W-1:0]       tag_s1;
  logic [PW-1:0]          sum;
  logic [DATA_W-1:0]      res_d;

  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  // Reset empties the pipe, so an offer is harmless while reset is high.
  assign in_ready  = ~stall | reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[PIPE_STAGES];

  // Bubbles travel as zeros; nothing collapses them.
  always_ff @(posedge clk) begin
    if (reset)   vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], accept};
  end

  // Partial-product array. Slice pairs with i+j >= NS only touch the high
  // word, so they are dropped when high results are not built.
  for (genvar i = 0; i < NS; i++) begin : g_a
    for (genvar j = 0; j < NS; j++) begin : g_b
`ifdef NIOS2_CPU_MULT_HIGH_EN
      localparam bit KEEP = 1'b1;
`else
      localparam bit KEEP = (i + j) < NS;
`endif
      if (KEEP) begin : g_pp
        nios2_cpu_mult_pp u_pp (
          .clk (clk),
          .en  (en),
          .a   (in_src1[i*PP_W +: PP_W]),
          .b   (in_src2[j*PP_W +: PP_W]),
          .p   (pp[i*NS+j])
        );
      end else begin : g_zero
        assign pp[i*NS+j] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) tag_s1 <= in_tag;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++)
        sum = sum + (PW'(pp[i*NS+j]) << (PP_W * (i + j)));
  end

`ifdef NIOS2_CPU_MULT_HIGH_EN
  // Signed high word = unsigned high word minus src2 (if src1 negative and
  // treated signed) minus src1 (if src2 negative and treated signed).
  mode_e              mode_in, mode_s1;
  logic [DATA_W-1:0]  corr_d, corr_s1;

  assign mode_in = mode_e'(in_mode);

  always_comb begin
    corr_d = '0;
    if ((mode_in == MULXSU || mode_in == MULXSS) && in_src1[DATA_W-1])
      corr_d = corr_d + in_src2;
    if (mode_in == MULXSS && in_src2[DATA_W-1])
      corr_d = corr_d + in_src1;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mode_s1 <= mode_in;
      corr_s1 <= corr_d;
    end
  end

  always_comb begin
    res_d = sum[DATA_W-1:0];
    if (mode_s1 != MUL) res_d = sum[PW-1:DATA_W] - corr_s1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{in_mode, sum[PW-1:DATA_W]};
  assign res_d       = sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (en) begin
      out_result <= res_d;
      out_tag    <= tag_s1;
    end
  end

endmodule

// File: tb/tb_nios2_cpu_mult_pipe.sv
// Scoreboard bench for nios2_cpu_mult_pipe: directed vectors push expected
// results at accept time; a negedge monitor pops and compares on each
// output handshake. Expected values depend on NIOS2_CPU_MULT_HIGH_EN.
module tb_nios2_cpu_mult_pipe;
  import nios2_cpu_mult_pkg::*;

  localparam int DW = 32;
  localparam int TW = 5;
`ifdef NIOS2_CPU_MULT_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_src1, in_src2, out_result;
  logic [TW-1:0] in_tag, out_tag;

  nios2_cpu_mult_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
  logic [DW-1:0] cur_exp;
  bit            lat_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor pops first, then records a new accept; an accept can never be
  // popped in the same cycle, so ordering between the two is safe.
  always @(negedge clk) begin
    exp_t e;
    if (reset) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: tag %0d result %0h with nothing pending", out_tag, out_result);
        end else begin
          e = sb.pop_front();
          n_out++;
          chk("result", 64'(out_result), 64'(e.res));
          chk("tag", 64'(out_tag), 64'(e.tag));
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, in_tag, cyc, lat_chk});
    end
  end

  task automatic send(input logic [1:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    cur_exp  = HIGH_EN ? exp_hi : exp_lo;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: tag %0d never accepted", tag);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_src1 = '0; in_src2 = '0; in_tag = '0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors: expected (high-enabled build, default build)
    send(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000001, 32'h00000001);
    send(MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32'h00000001);
    send(MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 32'h00000001);
    send(MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 32'h00000001);
    send(MULXSS, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 32'h00000000);
    send(MULXSS, 32'h80000000, 32'h00000002, 5'd6,  32'hFFFFFFFF, 32'h00000000);
    send(MUL,    32'h00020003, 32'h00040005, 5'd7,  32'h0016000F, 32'h0016000F);
    send(MULXUU, 32'h00020003, 32'h00040005, 5'd8,  32'h00000008, 32'h0016000F);
    send(MULXSU, 32'hFFFF0000, 32'h00010000, 5'd9,  32'hFFFFFFFF, 32'h00000000);
    send(MULXSS, 32'hFFFFFFFE, 32'h00000003, 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFA);
    send(MUL,    32'h0000FFFF, 32'h0000FFFF, 5'd11, 32'hFFFE0001, 32'hFFFE0001);
    idle(4);

    // Back-to-back stream, latency 2 each, no gaps
    for (int i = 0; i < 8; i++)
      send(MUL, DW'(i + 1), 32'd3, TW'(i), DW'(3 * (i + 1)), DW'(3 * (i + 1)));
    idle(4);

    // Backpressure: fill both stages, hold out_ready low for 4 cycles
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(MUL, 32'd7,     32'd6,     5'd12, 32'd42,       32'd42);
    send(MUL, 32'h100,   32'h100,   5'd13, 32'h00010000, 32'h00010000);
    in_valid = 1'b1; in_mode = MUL; in_src1 = 32'd5; in_src2 = 32'd5; in_tag = 5'd14;
    cur_exp  = 32'd25;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_result", 64'(out_result), 64'd42);
      chk("stall_tag", 64'(out_tag), 64'd12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(MUL, 32'd5, 32'd5, 5'd14, 32'd25, 32'd25);
    idle(4);
    lat_chk = 1'b1;

    // Reset with two operations in flight: neither may appear
    out_ready = 1'b0;
    send(MUL, 32'd2, 32'd2, 5'd20, 32'd4, 32'd4);
    send(MUL, 32'd3, 32'd3, 5'd21, 32'd9, 32'd9);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("in_ready_during_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_result", 64'(out_result), 64'd0);
    chk("flush_out_tag", 64'(out_tag), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    idle(4);

    send(MULXUU, 32'h00020003, 32'h00040005, 5'd30, 32'h00000008, 32'h0016000F);
    idle(6);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("output_count", 64'(n_out), 64'd23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
